// File: rtl/ctrl_branch_predictor_bht_if.sv
// Lookup/prediction/update bundle for the branch history table.
// master drives lookups and training, slave is the predictor.
interface ctrl_branch_predictor_bht_if #(
  parameter int PROG_CTR_WID = 10
);
  logic                    lookup_valid;
  logic [PROG_CTR_WID-1:0] lookup_pc;
  logic [PROG_CTR_WID-1:0] lookup_tgt;
  logic                    pred_valid;
  logic                    pred_taken;
  logic [PROG_CTR_WID-1:0] pred_tgt;
  logic                    upd_valid;
  logic [PROG_CTR_WID-1:0] upd_pc;
  logic                    upd_taken;
  logic [PROG_CTR_WID-1:0] upd_tgt;
  logic                    upd_mispredict;
  logic                    flush;
  logic                    init_busy;
  logic [15:0]             mispredict_cnt;

  modport master (
    output lookup_valid, lookup_pc, lookup_tgt,
    output upd_valid, upd_pc, upd_taken,
    output upd_tgt, upd_mispredict, flush,
    input  pred_valid, pred_taken, pred_tgt,
    input  init_busy, mispredict_cnt
  );

  modport slave (
    input  lookup_valid, lookup_pc, lookup_tgt,
    input  upd_valid, upd_pc, upd_taken,
    input  upd_tgt, upd_mispredict, flush,
    output pred_valid, pred_taken, pred_tgt,
    output init_busy, mispredict_cnt
  );
endinterface

// File: rtl/ctrl_branch_predictor_bht.sv
// Saturating-counter branch history table, cleared after reset.
// Optional target buffer: define BRANCH_TARGET_BUF_EN.
module ctrl_branch_predictor_bht #(
  parameter int PROG_CTR_WID = 10,
  parameter int BHT_DEPTH    = 64,
  parameter int CTR_BITS     = 2,
  parameter int IDX_LSB      = 0
) (
  input logic clk,
  input logic reset,
  ctrl_branch_predictor_bht_if.slave bus
);
  localparam int IW = $clog2(BHT_DEPTH);
  localparam logic [CTR_BITS-1:0] CMAX = '1;
  localparam logic [CTR_BITS-1:0] WNT =
    (CTR_BITS == 1) ? '0 :
    CTR_BITS'((1 << (CTR_BITS - 1)) - 1);

  typedef enum logic {INIT, READY} state_t;

  state_t              state;
  state_t              state_nxt;
  logic [IW-1:0]       init_idx;
  logic                init_last;
  logic [CTR_BITS-1:0] bht [BHT_DEPTH];
  logic [IW-1:0]       lk_idx;
  logic [IW-1:0]       up_idx;
  logic [CTR_BITS-1:0] up_ctr;
  logic [CTR_BITS-1:0] up_ctr_nxt;
  logic                rd_taken;
  logic [PROG_CTR_WID-1:0] seq_pc;
  logic [PROG_CTR_WID-1:0] taken_tgt;
  logic                upd_en;
  logic                unused_bits;

  assign lk_idx    = bus.lookup_pc[IDX_LSB +: IW];
  assign up_idx    = bus.upd_pc[IDX_LSB +: IW];
  assign init_last = (init_idx == IW'(BHT_DEPTH - 1));
  assign upd_en    = (state == READY) & bus.upd_valid;
  assign seq_pc    = bus.lookup_pc + PROG_CTR_WID'(1);

`ifdef BRANCH_TARGET_BUF_EN
  logic [PROG_CTR_WID-1:0] btb_tgt [BHT_DEPTH];
  logic                    btb_vld [BHT_DEPTH];

  assign taken_tgt = btb_vld[lk_idx] ?
                     btb_tgt[lk_idx] : bus.lookup_tgt;
  assign unused_bits = ^bus.upd_pc;

  // Target buffer: cleared during INIT, filled by taken branches
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        btb_vld[init_idx] <= 1'b0;
      end else if (upd_en && bus.upd_taken) begin
        btb_tgt[up_idx] <= bus.upd_tgt;
        btb_vld[up_idx] <= 1'b1;
      end
    end
  end
`else
  assign taken_tgt   = bus.lookup_tgt;
  assign unused_bits = ^{bus.upd_pc, bus.upd_tgt};
`endif

  // Next state, busy flag and counter arithmetic
  always_comb begin
    state_nxt     = state;
    bus.init_busy = (state == INIT);
    up_ctr        = bht[up_idx];
    up_ctr_nxt    = up_ctr;
    rd_taken      = 1'b0;
    if (state == INIT && init_last) begin
      state_nxt = READY;
    end
    if (state == READY) begin
      rd_taken = bht[lk_idx][CTR_BITS-1];
    end
    if (bus.upd_taken) begin
      if (up_ctr != CMAX) up_ctr_nxt = up_ctr + 1'b1;
    end else begin
      if (up_ctr != '0) up_ctr_nxt = up_ctr - 1'b1;
    end
  end

  // State register and sequential clear pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= INIT;
      init_idx <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) init_idx <= init_idx + 1'b1;
    end
  end

  // Counter table: clear during INIT, train in READY
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == INIT) begin
        bht[init_idx] <= WNT;
      end else if (upd_en) begin
        bht[up_idx] <= up_ctr_nxt;
      end
    end
  end

  // Registered prediction, read before same-cycle training
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pred_valid <= 1'b0;
      bus.pred_taken <= 1'b0;
      bus.pred_tgt   <= '0;
    end else begin
      bus.pred_valid <= bus.lookup_valid & ~bus.flush;
      if (bus.lookup_valid) begin
        bus.pred_taken <= rd_taken;
        bus.pred_tgt   <= rd_taken ? taken_tgt : seq_pc;
      end
    end
  end

  // Saturating mispredict counter
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.mispredict_cnt <= '0;
    end else if (upd_en && bus.upd_mispredict &&
                 bus.mispredict_cnt != 16'hFFFF) begin
      bus.mispredict_cnt <= bus.mispredict_cnt + 16'd1;
    end
  end
endmodule
